// File: rtl/line_fill_buffer.sv
// Line fill buffer: fetches one cache line as a single AXI INCR read burst and assembles it.
// Define LFB_EARLY_WORD_EN to add the early critical-word forward (early_block/valid/data).
module line_fill_buffer #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned BLOCK_SIZE = 6,
    parameter int unsigned ADDR_SIZE  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 fill_req,
    input  logic [ADDR_SIZE-1:0]                 fill_addr,
`ifdef LFB_EARLY_WORD_EN
    input  logic [BLOCK_SIZE-1:0]                early_block,
    output logic                                 early_valid,
    output logic [DATA_SIZE-1:0]                 early_data,
`endif
    output logic                                 fill_busy,
    output logic                                 fill_done,
    output logic                                 fill_err,
    output logic [2**BLOCK_SIZE-1:0][DATA_SIZE-1:0] fill_data,
    output logic [ADDR_SIZE-1:0]                 araddr,
    output logic [7:0]                           arlen,
    output logic [2:0]                           arsize,
    output logic [1:0]                           arburst,
    output logic                                 arvalid,
    input  logic                                 arready,
    input  logic [DATA_SIZE-1:0]                 rdata,
    input  logic [1:0]                           rresp,
    input  logic                                 rlast,
    input  logic                                 rvalid,
    output logic                                 rready
);

    localparam int unsigned BLOCKS    = 2 ** BLOCK_SIZE;
    localparam int unsigned BYTE_BITS = $clog2(DATA_SIZE / 8);
    localparam int unsigned OFF_BITS  = BLOCK_SIZE + BYTE_BITS;
    localparam logic [BLOCK_SIZE-1:0] LAST_CNT = BLOCK_SIZE'(BLOCKS - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e                state_q;
    logic [BLOCK_SIZE-1:0] cnt_q;
    logic                  err_q;
    logic                  beat;
    logic                  last_beat;
    logic                  beat_err;
    logic                  end_burst;

    assign arlen     = 8'(BLOCKS - 1);
    assign arsize    = 3'(BYTE_BITS);
    assign arburst   = 2'b01;
    assign fill_busy = (state_q != StIdle);

    assign beat      = (state_q == StData) && rvalid && rready;
    assign last_beat = (cnt_q == LAST_CNT);
    // The burst must end exactly on the last word; rlast anywhere else is a protocol error.
    assign beat_err  = err_q | (rresp != 2'b00) | (last_beat ? !rlast : rlast);
    assign end_burst = last_beat | rlast;

`ifdef LFB_EARLY_WORD_EN
    logic [BLOCK_SIZE-1:0] early_block_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            fill_data <= '0;
`ifdef LFB_EARLY_WORD_EN
            early_block_q <= '0;
            early_valid   <= 1'b0;
            early_data    <= '0;
`endif
        end else begin
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
`ifdef LFB_EARLY_WORD_EN
            early_valid <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (fill_req) begin
                        araddr  <= {fill_addr[ADDR_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        arvalid <= 1'b1;
                        state_q <= StAddr;
`ifdef LFB_EARLY_WORD_EN
                        early_block_q <= early_block;
`endif
                    end
                end
                StAddr: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (beat) begin
                        fill_data[cnt_q] <= rdata;
                        cnt_q            <= cnt_q + 1'b1;
                        err_q            <= beat_err;
`ifdef LFB_EARLY_WORD_EN
                        if (cnt_q == early_block_q) begin
                            early_valid <= 1'b1;
                            early_data  <= rdata;
                        end
`endif
                        if (end_burst) begin
                            rready    <= 1'b0;
                            fill_done <= 1'b1;
                            fill_err  <= beat_err;
                            state_q   <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: table of fill scenarios against an AXI slave model and scoreboard.
module tb_line_fill_buffer;

    localparam int unsigned DW = 32;
    localparam int unsigned BS = 6;
    localparam int unsigned AW = 32;
    localparam int unsigned NB = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   fill_req;
    logic [AW-1:0]          fill_addr;
    logic                   fill_busy;
    logic                   fill_done;
    logic                   fill_err;
    logic [NB-1:0][DW-1:0]  fill_data;
    logic [AW-1:0]          araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid;
    logic                   arready;
    logic [DW-1:0]          rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;
`ifdef LFB_EARLY_WORD_EN
    logic [BS-1:0]          early_block;
    logic                   early_valid;
    logic [DW-1:0]          early_data;
`endif

    always #5 clk = ~clk;

    line_fill_buffer #(
        .DATA_SIZE (DW),
        .BLOCK_SIZE(BS),
        .ADDR_SIZE (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
`ifdef LFB_EARLY_WORD_EN
        .early_block(early_block),
        .early_valid(early_valid),
        .early_data (early_data),
`endif
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_err   (fill_err),
        .fill_data  (fill_data),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] exp_araddr;
        int            ar_delay;
        bit            toggle;
        int            bad_beat;   // beat carrying SLVERR, -1 for none
        int            last_beat;  // last beat the slave sends
        bit            last_rlast; // rlast value on that beat
        bit            exp_err;
        int            exp_lat;    // cycle of fill_done, fill_req cycle = 1; 0 skips
        logic [DW-1:0] seed;
    } vec_t;

    typedef struct {
        logic                  err;
        logic [NB-1:0][DW-1:0] line;
    } exp_t;

    vec_t                  vecs[6];
    exp_t                  sb[$];
    logic [NB-1:0][DW-1:0] model;
    int                    checks = 0;
    int                    errors = 0;

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] seed, input int k);
        return seed + DW'(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [NB-1:0][DW-1:0] exp);
        checks++;
        if (fill_data !== exp) begin
            errors++;
            for (int k = 0; k < NB; k++) begin
                if (fill_data[k] !== exp[k]) begin
                    $display("FAIL %s word %0d got %0h want %0h", name, k, fill_data[k], exp[k]);
                    break;
                end
            end
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, 64'(fill_busy), 64'(0));
        chk({name, "_done"}, 64'(fill_done), 64'(0));
        chk({name, "_err"}, 64'(fill_err), 64'(0));
        chk({name, "_arvalid"}, 64'(arvalid), 64'(0));
        chk({name, "_rready"}, 64'(rready), 64'(0));
        chk({name, "_araddr"}, 64'(araddr), 64'(0));
        chk_line({name, "_data"}, '0);
`ifdef LFB_EARLY_WORD_EN
        chk({name, "_early_valid"}, 64'(early_valid), 64'(0));
        chk({name, "_early_data"}, 64'(early_data), 64'(0));
`endif
    endtask

    task automatic run_fill(input vec_t v);
        int   cyc;
        int   beat;
        int   waitc;
        int   early_cnt;
        bit   tog;
        bit   done;
        exp_t e;
        @(negedge clk);
        chk("idle_done_low", 64'(fill_done), 64'(0));
        chk("idle_busy_low", 64'(fill_busy), 64'(0));
        fill_req  = 1'b1;
        fill_addr = v.addr;
        cyc = 1; beat = 0; waitc = 0; early_cnt = 0; tog = 1'b1; done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            fill_req = 1'b0;
            if (fill_done) begin
                done = 1'b1;
                if (v.exp_lat != 0) chk("latency", 64'(cyc), 64'(v.exp_lat));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty got fill_done want none");
                end else begin
                    e = sb.pop_front();
                    chk("fill_err", 64'(fill_err), 64'(e.err));
                    chk_line("fill_data", e.line);
                end
            end
`ifdef LFB_EARLY_WORD_EN
            if (early_valid) begin
                early_cnt++;
                chk("early_data", 64'(early_data), 64'(pat(v.seed, 5)));
                chk("early_when", 64'(beat), 64'(6));
            end
`endif
            if (cyc == 2) chk("busy_addr", 64'(fill_busy), 64'(1));
            arready = arvalid && (waitc >= v.ar_delay);
            if (arvalid) begin
                chk("araddr", 64'(araddr), 64'(v.exp_araddr));
                chk("arlen", 64'(arlen), 64'(63));
                chk("arsize", 64'(arsize), 64'(2));
                chk("arburst", 64'(arburst), 64'(1));
                waitc++;
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            if (rready && beat <= v.last_beat) begin
                if (!v.toggle || tog) begin
                    rvalid = 1'b1;
                    rdata  = pat(v.seed, beat);
                    rresp  = (beat == v.bad_beat) ? 2'b10 : 2'b00;
                    rlast  = (beat == v.last_beat) ? v.last_rlast : 1'b0;
                    model[beat] = rdata;
                    if (beat == v.last_beat) begin
                        e.err  = v.exp_err;
                        e.line = model;
                        sb.push_back(e);
                    end
                    beat++;
                end
                tog = !tog;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout got no fill_done want fill_done within 400 cycles");
        end
`ifdef LFB_EARLY_WORD_EN
        chk("early_count", 64'(early_cnt), 64'(1));
`endif
        arready = 1'b0;
    endtask

    initial begin
        int  beat;
        bit  hit;
        vecs[0] = '{addr: 32'h0000_1234, exp_araddr: 32'h0000_1200, ar_delay: 0, toggle: 0,
                    bad_beat: -1, last_beat: 63, last_rlast: 1, exp_err: 0, exp_lat: 67,
                    seed: 32'h0};
        vecs[1] = '{addr: 32'hABCD_EFFF, exp_araddr: 32'hABCD_EF00, ar_delay: 5, toggle: 1,
                    bad_beat: -1, last_beat: 63, last_rlast: 1, exp_err: 0, exp_lat: 0,
                    seed: 32'h1000_0000};
        vecs[2] = '{addr: 32'h0000_0100, exp_araddr: 32'h0000_0100, ar_delay: 0, toggle: 0,
                    bad_beat: 10, last_beat: 63, last_rlast: 1, exp_err: 1, exp_lat: 67,
                    seed: 32'h2000_0000};
        vecs[3] = '{addr: 32'h0000_20FC, exp_araddr: 32'h0000_2000, ar_delay: 0, toggle: 0,
                    bad_beat: -1, last_beat: 31, last_rlast: 1, exp_err: 1, exp_lat: 35,
                    seed: 32'h3000_0000};
        vecs[4] = '{addr: 32'h0001_0080, exp_araddr: 32'h0001_0000, ar_delay: 2, toggle: 0,
                    bad_beat: -1, last_beat: 63, last_rlast: 0, exp_err: 1, exp_lat: 69,
                    seed: 32'h4000_0000};
        vecs[5] = '{addr: 32'hFFFF_FFFF, exp_araddr: 32'hFFFF_FF00, ar_delay: 0, toggle: 0,
                    bad_beat: -1, last_beat: 63, last_rlast: 1, exp_err: 0, exp_lat: 67,
                    seed: 32'h5000_0000};

        rst = 1'b1; fill_req = 1'b0; fill_addr = '0; arready = 1'b0;
        rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
`ifdef LFB_EARLY_WORD_EN
        early_block = 5;
`endif
        model = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Fills run back to back: each request lands in the cycle after the previous DONE.
        for (int i = 0; i < 6; i++) run_fill(vecs[i]);

        repeat (3) begin
            @(negedge clk);
            chk_line("hold_data", model);
            chk("single_done", 64'(fill_done), 64'(0));
        end

        // Reset on beat 20, with a competing fill_req that reset must override.
        @(negedge clk);
        fill_req  = 1'b1;
        fill_addr = 32'h0000_4000;
        beat = 0;
        hit  = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            fill_req = 1'b0;
            arready  = arvalid;
            rvalid   = 1'b0;
            if (rready) begin
                rvalid = 1'b1;
                rdata  = pat(32'h7000_0000, beat);
                if (beat == 20) begin
                    rst      = 1'b1;
                    fill_req = 1'b1;
                    hit      = 1'b1;
                end
                beat++;
            end
        end
        chk("rst_beat_reached", 64'(hit), 64'(1));
        @(negedge clk);
        chk_zero("abort");
        rst = 1'b0; fill_req = 1'b0; rvalid = 1'b0; arready = 1'b0;
        @(negedge clk);
        chk("rst_dominates_req", 64'(fill_busy), 64'(0));
        chk("abort_no_done", 64'(fill_done), 64'(0));
        model = '0;
        run_fill(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_buffer.md
LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 SHALL have parameters: DATA_SIZE, default 32, word width; BLOCK_SIZE, default 6, log2 words per line (BLOCKS = 2**BLOCK_SIZE); ADDR_SIZE, default 32, byte-address width.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  reset.
- fill_req  in  1  controller miss request.
- fill_addr  in  ADDR_SIZE  miss byte address.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle line-complete pulse.
- fill_err  out  1  error for the completed fill, valid with fill_done.
- fill_data  out  BLOCKS x DATA_SIZE  assembled line, feeds data_array data_in_m.
- araddr  out  ADDR_SIZE  AXI AR address.
- arlen  out  8  AXI AR length.
- arsize  out  3  AXI AR size.
- arburst  out  2  AXI AR burst type.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- rdata  in  DATA_SIZE  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.

Function
REQ-004 SHALL implement FSM IDLE, ADDR, DATA, DONE; fill_busy = (state != IDLE).
REQ-005 IDLE: fill_req=1 SHALL latch fill_addr with the low BLOCK_SIZE+log2(DATA_SIZE/8) bits zeroed, clear beat counter and error flag, and enter ADDR next cycle; fill_req in any other state SHALL be ignored.
REQ-006 ADDR: arvalid=1, araddr=latched line address, arlen=BLOCKS-1, arsize=log2(DATA_SIZE/8), arburst=2'b01 (INCR); these SHALL hold stable until arready=1, then the FSM enters DATA.
REQ-007 arvalid SHALL NOT depend combinationally on arready.
REQ-008 DATA: rready=1; each rvalid&rready beat SHALL write rdata into word[cnt] of fill_data and increment cnt (width BLOCK_SIZE).
REQ-009 rresp != 2'b00 on any beat SHALL set the sticky error flag.
REQ-010 The beat with cnt==BLOCKS-1 SHALL end DATA and enter DONE; rlast=0 on that beat SHALL set the error flag.
REQ-011 rlast=1 on a beat with cnt<BLOCKS-1 SHALL set the error flag and enter DONE; the unwritten words keep their prior contents.
REQ-012 DONE: fill_done=1 and fill_err=error flag for exactly one cycle, rready=0; the FSM then returns to IDLE.
REQ-013 fill_data SHALL remain stable from fill_done until the first beat of the next fill.
REQ-014 Minimum latency from fill_req to fill_done SHALL be BLOCKS+3 cycles, assuming arready and rvalid are held high.
REQ-015 Back-to-back fills: fill_req asserted in the cycle after DONE SHALL be accepted.

Reset
REQ-016 rst=1 SHALL force IDLE, and arvalid, rready, fill_busy, fill_done, fill_err, cnt, the error flag, araddr and all fill_data words to 0 at the next clock edge.
REQ-017 rst asserted mid-burst SHALL abort the fill with no fill_done pulse; rst dominates fill_req in the same cycle.

Configuration
REQ-018 Macro LFB_EARLY_WORD_EN: when defined, SHALL add ports early_block in BLOCK_SIZE (latched with fill_addr), early_valid out 1 and early_data out DATA_SIZE.
REQ-019 With LFB_EARLY_WORD_EN defined, in the cycle after the beat with cnt==early_block, early_valid SHALL pulse for one cycle with that beat's rdata on early_data (both reset to 0).
REQ-020 Without LFB_EARLY_WORD_EN, these ports SHALL NOT exist and behaviour SHALL be otherwise identical.

Verification
REQ-021 Fill at addr 0x0000_1234, arready/rvalid held high, rdata=beat index: araddr=0x0000_1200, arlen=63, arburst=1; fill_done at cycle 67; fill_data[k]=k; fill_err=0.
REQ-022 arready delayed 5 cycles, rvalid toggling 1/0: AR fields stable while waiting; all 64 words correct; exactly one fill_done pulse.
REQ-023 rresp=2'b10 on beat 10: fill_err=1 with fill_done; other words are stored normally.
REQ-024 rlast=1 on beat 31: DONE after beat 31 with fill_err=1; rlast=0 on beat 63 also gives fill_err=1.
REQ-025 rst asserted on beat 20: next cycle is IDLE with all outputs 0 and no fill_done; a new fill then completes correctly.
REQ-026 LFB_EARLY_WORD_EN defined, early_block=5: early_valid pulses once, in the cycle after beat 5, with early_data=5.
